spi_slave_rx_fifo: RTL and testbench
====================================

Name: spi_slave_rx_fifo

Overview:
- Fabric-side SPI slave on the far end of the Nios SPI master port (spi_external_*); consumes the serial frames that port produces.
- Oversamples SCLK/MOSI/SS_n in the system clock domain and deserialises MSB-first words.
- Buffers received words in a FIFO presented as a valid/ready stream to downstream logic (hex/LED drivers, sample processing).
- Shifts a reply word out on MISO during every word slot.

Parameters:
DATA_W, 8, bits per SPI word (4..32)
FIFO_DEPTH, 8, receive FIFO entries; power of 2, at least 2
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level (derived, do not override)

Ports:
clk_clk  in  1  system clock; must be at least 8x the SCLK frequency
reset_reset  in  1  synchronous, active-high reset
spi_external_SCLK  in  1  SPI clock from master, asynchronous
spi_external_MOSI  in  1  master-out data, asynchronous
spi_external_SS_n  in  1  active-low slave select, asynchronous
spi_external_MISO  out  1  slave-out data
tx_data  in  DATA_W  reply word, sampled at each word start
out_data  out  DATA_W  FIFO head word
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_data
fifo_level  out  LVL_W  words currently held
overflow  out  1  sticky: a word was dropped
overflow_clr  in  1  clears overflow
frame_err  out  1  1-cycle pulse: SS_n deasserted mid-word

Behaviour:
- Reset values: spi_external_MISO=0, out_valid=0, out_data=0, fifo_level=0, overflow=0, frame_err=0. Synchroniser flops reset to idle levels: SCLK=0, SS_n=1.
- Synchronisation:
  - Each SPI input passes through 2 flops, then an edge-detect register.
  - A pin transition is therefore seen as an edge event 3 clk_clk cycles later.
- SPI mode 0 (CPOL=0, CPHA=0):
  - MOSI is sampled on SCLK rising events.
  - MISO changes on SCLK falling events.
  - MSB first.
- Receive FSM states:
  - IDLE: SS_n synced high; bit_cnt=0.
  - SS_n falling event -> ACTIVE; load tx shift register with tx_data; MISO = tx_data[DATA_W-1].
  - ACTIVE, rising event: shift synced MOSI into rx_shift; bit_cnt++.
  - When bit_cnt reaches DATA_W: assert an internal push for 1 cycle with the completed word; bit_cnt->0; reload tx shift register with tx_data on the next falling event; stay in ACTIVE (back-to-back words allowed).
  - ACTIVE, falling event: shift the tx register; MISO = next bit.
  - SS_n rising event -> IDLE; MISO=0.
  - If bit_cnt != 0 at that point: discard the partial word and pulse frame_err for 1 cycle. No FIFO write.
  - SCLK edges while in IDLE are ignored.
- FIFO:
  - Synchronous, registered head. Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Pop = out_valid & out_ready.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A push is refused when full with no pop. The refused word is lost and overflow is set.
- Timing:
  - Pushed word appears on out_data with out_valid=1 the cycle after the push.
  - fifo_level updates in the same cycle as the pointers change.
  - Simultaneous push and pop: fifo_level is unchanged.
- overflow:
  - Sticky; cleared by overflow_clr.
  - If overflow_clr and a new overflow occur in the same cycle, set wins.
- Reset mid-frame: FSM -> IDLE, FIFO emptied, partial word discarded, no frame_err.
- A frame restarts only after a fresh SS_n falling event.
- out_data holds its value while out_valid=0.

Optional Feature:
SPI_RX_ECHO_EN
- Defined: the tx shift register loads the most recently completed received word (0 after reset) instead of tx_data. tx_data is unused. Lets the master loop-back test the link.
- Undefined: MISO returns tx_data as described above.

Test Plan:
- Single word: SS_n low, shift 0xA5, SS_n high (SCLK=clk/8) -> out_valid=1 with out_data=0xA5, fifo_level=1; MISO bits match tx_data=0x3C, MSB first; frame_err stays 0.
- Back-to-back: one frame carries 0x01..0x04 with out_ready=0 -> fifo_level=4; then out_ready=1 -> 0x01, 0x02, 0x03, 0x04 popped in order; out_valid=0 after.
- Overflow: 9 words into DEPTH=8 with out_ready=0 -> fifo_level=8, overflow=1, head=first word; pulse overflow_clr -> overflow=0.
- Abort: SS_n rises after 5 bits -> frame_err is a 1-cycle pulse, fifo_level unchanged; the next full frame 0x7E is received correctly.
- Full + simultaneous pop/push: FIFO full with out_ready=1 while the 9th word completes -> no overflow, fifo_level stays 8.
- Reset mid-word, and echo mode: assert reset_reset after 3 bits -> all outputs at reset values. With SPI_RX_ECHO_EN defined, send 0x55 then 0x00 -> MISO on the second word carries 0x55.

Source files
------------

// File: rtl/spi_slave_rx_fifo.sv
// Oversampled SPI mode-0 slave receiver feeding a valid/ready word FIFO.
// Define SPI_RX_ECHO_EN to return the last received word on MISO instead of tx_data.
//
// state  | meaning
// IDLE   | slave not selected, SCLK ignored, bit counter cleared
// ACTIVE | slave selected, words shifted on synced SCLK edge events
module spi_slave_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_external_SCLK,
    input  logic              spi_external_MOSI,
    input  logic              spi_external_SS_n,
    output logic              spi_external_MISO,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    input  logic              overflow_clr,
    output logic              frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

    logic [1:0] sclk_sync, mosi_sync, ss_sync;
    logic       sclk_d, ss_d;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ss_sync   <= 2'b11;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_external_SCLK};
            mosi_sync <= {mosi_sync[0], spi_external_MOSI};
            ss_sync   <= {ss_sync[0], spi_external_SS_n};
            sclk_d    <= sclk_sync[1];
            ss_d      <= ss_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign ss_rise   = ss_sync[1] & ~ss_d;
    assign ss_fall   = ~ss_sync[1] & ss_d;

    state_t            state, state_nxt;
    logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_W-2:0] rx_shift, rx_shift_nxt;
    logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
    logic [DATA_W-1:0] rx_word, load_word;
    logic              reload, reload_nxt, push, frame_err_nxt;

    assign rx_word           = {rx_shift, mosi_sync[1]};
    assign spi_external_MISO = tx_shift[DATA_W-1];

`ifdef SPI_RX_ECHO_EN
    logic [DATA_W-1:0] last_rx;
    logic              unused_tx;
    assign unused_tx = ^tx_data;
    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            last_rx <= '0;
        else if (push)
            last_rx <= rx_word;
    end
    assign load_word = last_rx;
`else
    assign load_word = tx_data;
`endif

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        rx_shift_nxt  = rx_shift;
        tx_shift_nxt  = tx_shift;
        reload_nxt    = reload;
        push          = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (ss_fall) begin
                    state_nxt    = ACTIVE;
                    tx_shift_nxt = load_word;
                    reload_nxt   = 1'b0;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nxt     = IDLE;
                    bit_cnt_nxt   = '0;
                    tx_shift_nxt  = '0;
                    frame_err_nxt = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    rx_shift_nxt = rx_word[DATA_W-2:0];
                    if (bit_cnt == CW'(DATA_W - 1)) begin
                        push        = 1'b1;
                        bit_cnt_nxt = '0;
                        reload_nxt  = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else if (sclk_fall) begin
                    // the falling edge after a completed word starts the next reply word
                    if (reload) begin
                        tx_shift_nxt = load_word;
                        reload_nxt   = 1'b0;
                    end else begin
                        tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            reload    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rx_shift  <= rx_shift_nxt;
            tx_shift  <= tx_shift_nxt;
            reload    <= reload_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic              pop, wr_en, full;

    assign fifo_level = LVL_W'(wr_ptr - rd_ptr);
    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign out_valid  = (fifo_level != '0);
    assign pop        = out_valid & out_ready;
    assign wr_en      = push & (~full | pop);
    assign wr_ptr_nxt = wr_ptr + PW'(wr_en);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);

    always_ff @(posedge clk_clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= rx_word;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            out_data <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            // bypass when the incoming word becomes the new head
            if (wr_en && (rd_ptr_nxt == wr_ptr))
                out_data <= rx_word;
            else if (wr_ptr_nxt != rd_ptr_nxt)
                out_data <= mem[rd_ptr_nxt[AW-1:0]];
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// Scoreboard bench for spi_slave_rx_fifo: SPI master stimulus, queue-based FIFO model.
`timescale 1ns/1ps
module tb_spi_slave_rx_fifo;
    localparam int DEPTH = 8;
`ifdef SPI_RX_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk_clk = 1'b0, reset_reset = 1'b1;
    logic       sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1, miso;
    logic [7:0] tx_data = 8'h00, out_data;
    logic       out_valid, out_ready = 1'b0, overflow, overflow_clr = 1'b0, frame_err;
    logic [3:0] fifo_level;

    int         n_checks = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf = 1'b0, rdy_rand = 1'b0;
    logic [7:0] last_word = 8'h00;
    int         ferr_exp = 0, ferr_seen = 0;

    spi_slave_rx_fifo dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .spi_external_SCLK(sclk), .spi_external_MOSI(mosi), .spi_external_SS_n(ss_n),
        .spi_external_MISO(miso), .tx_data(tx_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr),
        .frame_err(frame_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every accepted transfer
    initial forever begin
        @(negedge clk_clk);
        #2;
        if (frame_err === 1'b1) ferr_seen++;
        if (!reset_reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h with no word expected", out_data);
            end else begin
                check("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk_clk);
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic half();
        repeat (4) @(negedge clk_clk);
    endtask

    task automatic ss_low();
        ss_n = 1'b0;
        repeat (8) @(negedge clk_clk);
    endtask

    task automatic ss_high();
        half();
        ss_n = 1'b1;
        repeat (8) @(negedge clk_clk);
    endtask

    // sel: 0 plain, 1 pop in the push cycle, 2 overflow_clr in the push cycle
    task automatic send_word(input logic [7:0] w, input logic [7:0] next_tx, input int sel);
        logic [7:0] exp_m, got_m;
        bit         acc;
        exp_m = ECHO ? last_word : tx_data;
        got_m = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi = w[i];
            half();
            if (i == 7) tx_data = next_tx;
            got_m[i] = miso;
            sclk = 1'b1;
            if (i == 0) begin
                acc = (exp_q.size() < DEPTH) || (sel == 1);
                if (acc) exp_q.push_back(w);
                if (!acc) exp_ovf = 1'b1;
                else if (sel == 2) exp_ovf = 1'b0;
                last_word = w;
                repeat (2) @(negedge clk_clk);
                if (sel == 1) out_ready = 1'b1;
                if (sel == 2) overflow_clr = 1'b1;
                @(negedge clk_clk);
                out_ready = 1'b0;
                overflow_clr = 1'b0;
                @(negedge clk_clk);
            end else begin
                half();
            end
            sclk = 1'b0;
        end
        check("miso_word", got_m, exp_m);
    endtask

    task automatic send_partial(input logic [7:0] w, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = w[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, fifo_level, exp_q.size());
        check({tag, "_overflow"}, overflow, exp_ovf);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        while (out_valid && t < 100) begin
            @(negedge clk_clk);
            t++;
        end
        out_ready = 1'b0;
        @(negedge clk_clk);
        check("drain_valid", out_valid, 1'b0);
        check("drain_model", exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        overflow_clr = 1'b1;
        @(negedge clk_clk);
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk_clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, miso, 1'b0);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"}, out_data, 8'h00);
        check({tag, "_level"}, fifo_level, 4'd0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_ferr"}, frame_err, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        int n;
        repeat (4) @(negedge clk_clk);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        check_reset_values("reset");

        // single word
        tx_data = 8'h3C;
        ss_low();
        send_word(8'hA5, 8'($urandom), 0);
        ss_high();
        check("single_data", out_data, 8'hA5);
        check("single_valid", out_valid, 1'b1);
        check_status("single");
        drain();

        // back-to-back words in one frame
        ss_low();
        for (int j = 1; j <= 4; j++) send_word(8'(j), 8'($urandom), 0);
        ss_high();
        check_status("b2b");
        drain();

        // overflow, then clear; then clear colliding with a new overflow
        ss_low();
        for (int j = 0; j < 9; j++) send_word(8'($urandom), 8'($urandom), 0);
        ss_high();
        check_status("ovf");
        check("ovf_head", out_data, exp_q[0]);
        pulse_clr();
        check_status("ovf_clr");
        ss_low();
        send_word(8'($urandom), 8'($urandom), 2);
        ss_high();
        check_status("ovf_setwins");
        pulse_clr();
        check_status("ovf_clr2");

        // full FIFO with a pop in the push cycle
        ss_low();
        send_word(8'($urandom), 8'($urandom), 1);
        ss_high();
        check_status("full_poppush");
        drain();

        // abort after 5 bits, then a clean frame
        ss_low();
        send_partial(8'($urandom), 5);
        ss_high();
        ferr_exp++;
        check("abort_ferr", ferr_seen, ferr_exp);
        check_status("abort");
        ss_low();
        send_word(8'h7E, 8'($urandom), 0);
        ss_high();
        check("after_abort_data", out_data, 8'h7E);
        check_status("after_abort");
        drain();

        // reset in the middle of a word
        ss_low();
        send_word(8'($urandom), 8'($urandom), 0);
        send_partial(8'($urandom), 3);
        reset_reset = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        last_word = 8'h00;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        check_reset_values("midreset");
        repeat (8) @(negedge clk_clk);
        check("midreset_noferr", ferr_seen, ferr_exp);

        // echo pattern
        ss_low();
        send_word(8'h55, 8'($urandom), 0);
        send_word(8'h00, 8'($urandom), 0);
        ss_high();
        check_status("echo");
        drain();

        // randomized frames with random back-pressure and occasional aborts
        for (int k = 0; k < 12; k++) begin
            rdy_rand = 1'b1;
            tx_data = 8'($urandom);
            n = $urandom_range(1, 4);
            ss_low();
            for (int j = 0; j < n; j++) begin
                w = 8'($urandom);
                send_word(w, 8'($urandom), 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                send_partial(8'($urandom), $urandom_range(1, 7));
                ferr_exp++;
            end
            ss_high();
            drain();
            check("rand_overflow", overflow, exp_ovf);
        end

        check("ferr_total", ferr_seen, ferr_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
